// File: rtl/sequencer_program_loader.sv
// ============================================================================
// sequencer_program_loader: streams a host program into one daisy-chained
// sequencer cell's IRAM, optionally calls it, then reports done/err.
// Revision: 1.0
// ============================================================================
`default_nettype none

module sequencer_program_loader #(
    parameter int INSTR_DATA_WIDTH = 32,
    parameter int INSTR_ADDR_WIDTH = 6,
    parameter int INSTR_HOPS_WIDTH = 4,
    parameter int NUM_CELLS        = 16,
    parameter int TIMEOUT_CYCLES   = 1000000
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic [INSTR_HOPS_WIDTH-1:0]   cmd_hops,
    input  logic [INSTR_ADDR_WIDTH:0]     cmd_len,
    input  logic                          cmd_exec,
    input  logic [INSTR_DATA_WIDTH-1:0]   prog_data,
    input  logic                          prog_valid,
    output logic                          prog_ready,
    input  logic                          abort,
    output logic [INSTR_DATA_WIDTH-1:0]   instr_data_out,
    output logic [INSTR_ADDR_WIDTH-1:0]   instr_addr_out,
    output logic [INSTR_HOPS_WIDTH-1:0]   instr_hops_out,
    output logic                          instr_en_out,
    output logic [NUM_CELLS-1:0]          call,
    input  logic [NUM_CELLS-1:0]          ret,
    output logic                          busy,
    output logic                          done,
    output logic                          err
);

    localparam int                        DEPTH       = 1 << INSTR_ADDR_WIDTH;
    localparam logic [INSTR_ADDR_WIDTH:0] c_DEPTH     = (INSTR_ADDR_WIDTH+1)'(DEPTH);
    localparam logic [INSTR_HOPS_WIDTH:0] c_NUM_CELLS = (INSTR_HOPS_WIDTH+1)'(NUM_CELLS);
    localparam logic [31:0]               c_TO_LAST   = 32'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_DRAIN = 3'd2,
        S_CALL  = 3'd3,
        S_RUN   = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t                        r_state;
    state_t                        w_next;
    logic                          w_err;
    logic                          w_wr;
    logic                          w_cmd_hs;
    logic [NUM_CELLS-1:0]          w_onehot;

    logic [INSTR_HOPS_WIDTH-1:0]   r_hops;
    logic [INSTR_ADDR_WIDTH:0]     r_len;
    logic                          r_exec;
    logic [INSTR_ADDR_WIDTH:0]     r_addr;
    logic [INSTR_HOPS_WIDTH:0]     r_drain;
    logic [31:0]                   r_tcnt;

    logic [INSTR_DATA_WIDTH-1:0]   r_data_out;
    logic [INSTR_ADDR_WIDTH-1:0]   r_addr_out;
    logic [INSTR_HOPS_WIDTH-1:0]   r_hops_out;
    logic                          r_en_out;
    logic [NUM_CELLS-1:0]          r_call;
    logic                          r_busy;
    logic                          r_done;
    logic                          r_err;

    // Gated with rst_n so every output reads 0 while reset is held.
    assign cmd_ready  = (r_state == S_IDLE) && rst_n;
    assign prog_ready = (r_state == S_LOAD);
    assign w_cmd_hs   = cmd_valid && (r_state == S_IDLE);

    always_comb begin
        w_next   = r_state;
        w_err    = 1'b0;
        w_wr     = 1'b0;
        w_onehot = '0;
        w_onehot[r_hops] = 1'b1;
        case (r_state)
            S_IDLE: begin
                if (cmd_valid) begin
                    if (({1'b0, cmd_hops} >= c_NUM_CELLS) || (cmd_len > c_DEPTH)) begin
                        w_next = S_DONE;
                        w_err  = 1'b1;
                    end else if (cmd_len == '0) begin
                        w_next = S_DRAIN;
                    end else begin
                        w_next = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                if (abort) begin
                    w_next = S_DONE;
                    w_err  = 1'b1;
                end else if (prog_valid) begin
                    w_wr = 1'b1;
                    if (r_addr == r_len - 1'b1) begin
                        w_next = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                // hops+2 cycles here leaves hops+1 quiet cycles after the last strobe
                if (abort) begin
                    w_next = S_DONE;
                    w_err  = 1'b1;
                end else if (r_drain == ({1'b0, r_hops} + 1'b1)) begin
                    w_next = r_exec ? S_CALL : S_DONE;
                end
            end
            S_CALL: begin
                if (abort) begin
                    w_next = S_DONE;
                    w_err  = 1'b1;
                end else begin
                    w_next = S_RUN;
                end
            end
            S_RUN: begin
                if (abort) begin
                    w_next = S_DONE;
                    w_err  = 1'b1;
                end else if (ret[r_hops]) begin
                    w_next = S_DONE;
                end else if ((TIMEOUT_CYCLES != 0) && (r_tcnt == c_TO_LAST)) begin
                    w_next = S_DONE;
                    w_err  = 1'b1;
                end
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_hops     <= '0;
            r_len      <= '0;
            r_exec     <= 1'b0;
            r_addr     <= '0;
            r_drain    <= '0;
            r_tcnt     <= '0;
            r_data_out <= '0;
            r_addr_out <= '0;
            r_hops_out <= '0;
            r_en_out   <= 1'b0;
            r_call     <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_cmd_hs) begin
                r_hops <= cmd_hops;
                r_len  <= cmd_len;
                r_exec <= cmd_exec;
                r_addr <= '0;
            end else if (w_wr) begin
                r_addr <= r_addr + 1'b1;
            end
            r_drain  <= (r_state == S_DRAIN) ? r_drain + 1'b1 : '0;
            r_tcnt   <= (r_state == S_RUN) ? r_tcnt + 32'd1 : '0;
            r_en_out <= w_wr;
            if (w_wr) begin
                r_data_out <= prog_data;
                r_addr_out <= r_addr[INSTR_ADDR_WIDTH-1:0];
                r_hops_out <= r_hops;
            end
            r_call <= (w_next == S_CALL) ? w_onehot : '0;
            r_busy <= (w_next != S_IDLE);
            r_done <= (w_next == S_DONE);
            r_err  <= (w_next == S_DONE) && w_err;
        end
    end

    assign instr_data_out = r_data_out;
    assign instr_addr_out = r_addr_out;
    assign instr_hops_out = r_hops_out;
    assign instr_en_out   = r_en_out;
    assign call           = r_call;
    assign busy           = r_busy;
    assign done           = r_done;
    assign err            = r_err;

endmodule

`default_nettype wire

// File: tb/tb_sequencer_program_loader.sv
// ============================================================================
// tb_sequencer_program_loader: randomized scoreboard bench; a cycle-stamped
// event model of the loader feeds queues drained by an output monitor.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_sequencer_program_loader;

    localparam int DW = 32;
    localparam int AW = 6;
    localparam int HW = 4;
    localparam int NC = 12;
    localparam int TO = 8;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            cmd_valid = 1'b0;
    logic            cmd_ready;
    logic [HW-1:0]   cmd_hops = '0;
    logic [AW:0]     cmd_len = '0;
    logic            cmd_exec = 1'b0;
    logic [DW-1:0]   prog_data = '0;
    logic            prog_valid = 1'b0;
    logic            prog_ready;
    logic            abort = 1'b0;
    logic [DW-1:0]   instr_data_out;
    logic [AW-1:0]   instr_addr_out;
    logic [HW-1:0]   instr_hops_out;
    logic            instr_en_out;
    logic [NC-1:0]   call;
    logic [NC-1:0]   ret = '0;
    logic            busy;
    logic            done;
    logic            err;

    sequencer_program_loader #(
        .INSTR_DATA_WIDTH (DW),
        .INSTR_ADDR_WIDTH (AW),
        .INSTR_HOPS_WIDTH (HW),
        .NUM_CELLS        (NC),
        .TIMEOUT_CYCLES   (TO)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_hops       (cmd_hops),
        .cmd_len        (cmd_len),
        .cmd_exec       (cmd_exec),
        .prog_data      (prog_data),
        .prog_valid     (prog_valid),
        .prog_ready     (prog_ready),
        .abort          (abort),
        .instr_data_out (instr_data_out),
        .instr_addr_out (instr_addr_out),
        .instr_hops_out (instr_hops_out),
        .instr_en_out   (instr_en_out),
        .call           (call),
        .ret            (ret),
        .busy           (busy),
        .done           (done),
        .err            (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int c; logic [DW-1:0] d; int a; int h; } wr_t;
    typedef struct { int c; int v; } ev_t;

    wr_t wq[$];
    ev_t cq[$];
    ev_t dq[$];

    int checks = 0;
    int errors = 0;
    int rdy_cyc = 0;
    bit after_done = 1'b0;

    task automatic check(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: every DUT event must match the oldest expected one, cycle-exact.
    always @(negedge clk) begin
        if (rst_n) begin
            if (instr_en_out) begin
                if (wq.size() == 0) check("unexpected_write", 1, 0);
                else begin
                    wr_t w;
                    w = wq.pop_front();
                    check("write_cycle", cyc, w.c);
                    check("write_payload", {instr_data_out, instr_addr_out, instr_hops_out},
                          {w.d, AW'(w.a), HW'(w.h)});
                end
            end
            if (call != '0) begin
                if (cq.size() == 0) check("unexpected_call", longint'(call), 0);
                else begin
                    ev_t e;
                    logic [NC-1:0] oh;
                    e = cq.pop_front();
                    oh = NC'(1) << e.v;
                    check("call_cycle", cyc, e.c);
                    check("call_vector", call, oh);
                end
            end
            if (done) begin
                if (dq.size() == 0) check("unexpected_done", 1, 0);
                else begin
                    ev_t e;
                    e = dq.pop_front();
                    check("done_cycle", cyc, e.c);
                    check("done_err", err, e.v);
                end
            end
        end
    end

    task automatic wait_cyc(input int x);
        while (cyc < x) @(negedge clk);
    endtask

    task automatic issue_cmd(input int h, input int L, input bit e, output int t0);
        wait_cyc(rdy_cyc - 1);
        if (after_done && cyc == rdy_cyc - 1 && $urandom_range(0, 1) == 1) begin
            cmd_valid = 1'b1; cmd_hops = HW'(h); cmd_len = (AW+1)'(L); cmd_exec = e;
            check("cmd_ready_in_done", cmd_ready, 0);
            @(negedge clk);
        end
        wait_cyc(rdy_cyc);
        cmd_valid = 1'b1; cmd_hops = HW'(h); cmd_len = (AW+1)'(L); cmd_exec = e;
        check("cmd_ready", cmd_ready, 1);
        check("busy_idle", busy, 0);
        t0 = cyc;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    // ab_idx: word index handshaken together with abort (-1 none)
    // ret_d / ab_run: cycles after the call pulse for ret / abort (0 none)
    task automatic run_cmd(input int h, input int L, input bit e, input int gap_pct,
                           input int ab_idx, input int ret_d, input int ab_run);
        int t0, tl, tc, fin, kmax, i;
        logic [DW-1:0] w;
        issue_cmd(h, L, e, t0);
        after_done = 1'b1;
        if (h >= NC || L > (1 << AW)) begin
            dq.push_back('{t0 + 1, 1});
            rdy_cyc = t0 + 2;
            return;
        end
        tl = t0;
        i = 0;
        while (i < L) begin
            if ($urandom_range(0, 99) < gap_pct) prog_valid = 1'b0;
            else begin
                prog_valid = 1'b1;
                w = $urandom;
                prog_data = w;
                check("prog_ready", prog_ready, 1);
                if (i == ab_idx) begin
                    abort = 1'b1;
                    dq.push_back('{cyc + 1, 1});
                    rdy_cyc = cyc + 2;
                    @(negedge clk);
                    abort = 1'b0;
                    prog_valid = 1'b0;
                    return;
                end
                wq.push_back('{cyc + 1, w, i, h});
                tl = cyc;
                i++;
            end
            @(negedge clk);
        end
        prog_valid = 1'b0;
        tc = tl + h + 3;
        if (!e) begin
            dq.push_back('{tc, 0});
            rdy_cyc = tc + 1;
            return;
        end
        cq.push_back('{tc, h});
        // ret to the target while draining must be ignored
        wait_cyc(tl + 2);
        ret[h] = 1'b1;
        @(negedge clk);
        ret = '0;
        if (ab_run > 0 && ab_run <= TO && (ret_d == 0 || ab_run <= ret_d)) begin
            fin = tc + ab_run + 1; dq.push_back('{fin, 1});
        end else if (ret_d > 0 && ret_d <= TO) begin
            fin = tc + ret_d + 1; dq.push_back('{fin, 0});
        end else begin
            fin = tc + TO + 1; dq.push_back('{fin, 1});
        end
        rdy_cyc = fin + 1;
        kmax = (ret_d > ab_run) ? ret_d : ab_run;
        if (kmax < 1) kmax = 1;
        if (kmax > TO + 1) kmax = TO + 1;
        for (int k = 1; k <= kmax; k++) begin
            wait_cyc(tc + k);
            ret = '0;
            if (k == 1 && ret_d != 1) ret[(h + 1) % NC] = 1'b1;
            if (k == ret_d) ret[h] = 1'b1;
            abort = (k == ab_run);
            @(negedge clk);
        end
        ret = '0;
        abort = 1'b0;
    endtask

    task automatic reset_mid_load();
        int t0;
        logic [DW-1:0] w;
        issue_cmd(9, 64, 1'b0, t0);
        for (int i = 0; i < 20; i++) begin
            w = $urandom;
            prog_valid = 1'b1;
            prog_data = w;
            wq.push_back('{cyc + 1, w, i, 9});
            @(negedge clk);
        end
        prog_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("rst_outputs", {instr_en_out, call, busy, done, err, cmd_ready, prog_ready}, 0);
        check("rst_bus", {instr_data_out, instr_addr_out, instr_hops_out}, 0);
        check("rst_pending_writes", wq.size(), 0);
        wq.delete(); cq.delete(); dq.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post_rst_cmd_ready", cmd_ready, 1);
        check("post_rst_busy", busy, 0);
        rdy_cyc = cyc + 1;
        after_done = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        #1;
        check("reset_outputs", {instr_en_out, call, busy, done, err, prog_ready}, 0);
        check("reset_cmd_ready_low", cmd_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("reset_cmd_ready", cmd_ready, 1);
        rdy_cyc = cyc + 1;

        run_cmd(0, 3, 1'b1, 0, -1, 5, 0);      // basic
        run_cmd(5, 2, 1'b0, 50, -1, 0, 0);     // far cell with gaps
        run_cmd(NC, 3, 1'b1, 0, -1, 0, 0);     // illegal hops
        run_cmd(2, 65, 1'b1, 0, -1, 0, 0);     // illegal length
        run_cmd(1, 2, 1'b1, 0, -1, 0, 0);      // timeout, ret[2] ignored
        run_cmd(3, 4, 1'b1, 0, 1, 0, 0);       // abort on 2nd word
        run_cmd(7, 5, 1'b1, 20, -1, TO, 0);    // ret on the last timeout cycle
        run_cmd(4, 0, 1'b1, 0, -1, 3, 0);      // zero-length load
        run_cmd(2, 1, 1'b1, 0, -1, 3, 3);      // abort beats ret
        for (int n = 0; n < 12; n++) begin
            int h, L, ai, ar;
            h  = $urandom_range(0, 13);
            L  = ($urandom_range(0, 9) == 0) ? 65 : $urandom_range(0, 12);
            ai = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 12) : -1;
            ar = ($urandom_range(0, 4) == 0) ? $urandom_range(1, TO) : 0;
            run_cmd(h, L, 1'(($urandom_range(0, 1))), 30, ai, $urandom_range(0, TO + 2), ar);
        end
        run_cmd(11, 64, 1'b0, 10, -1, 0, 0);   // full IRAM
        reset_mid_load();
        run_cmd(6, 4, 1'b1, 10, -1, 2, 0);     // recovery after reset

        wait_cyc(rdy_cyc + 2);
        check("writes_left", wq.size(), 0);
        check("calls_left", cq.size(), 0);
        check("dones_left", dq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
